// File: rtl/button_pulse_gen.sv
// Synchronises and debounces the UP/DOWN pushbuttons and emits one-cycle step pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses; by default each press gives one pulse.
module button_pulse_gen #(
    parameter int DB_CYCLES    = 500000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int CNT_W        = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic up_level,
    output logic down_level
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_timing
        $error("button_pulse_gen: DB_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 2");
    end
    if ((longint'(DB_CYCLES) > (longint'(1) << CNT_W)) ||
        (longint'(REPEAT_DELAY) > (longint'(1) << CNT_W))) begin : g_bad_width
        $error("button_pulse_gen: CNT_W too narrow for the timing parameters");
    end

    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_pulse;

    assign w_raw = {btn_down_raw, btn_up_raw};

    // Index 0 is UP, index 1 is DOWN; each button gates its pulses on the other's level.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        localparam int OTH = 1 - b;

        logic             r_sync_p0;
        logic             r_sync_p1;
        logic [CNT_W-1:0] r_dc;
        logic             r_lvl;
        logic             r_lvl_d;
        logic             r_pulse;
        logic             w_press;
        logic             w_fire;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync_p0 <= 1'b0;
                r_sync_p1 <= 1'b0;
            end else begin
                r_sync_p0 <= w_raw[b];
                r_sync_p1 <= r_sync_p0;
            end
        end

        // Accept a new level only after DB_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_dc  <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync_p1 == r_lvl) begin
                r_dc <= '0;
            end else if (r_dc == DB_LAST) begin
                r_lvl <= r_sync_p1;
                r_dc  <= '0;
            end else begin
                r_dc <= r_dc + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_lvl_d <= 1'b0;
            end else begin
                r_lvl_d <= r_lvl;
            end
        end

        assign w_press = r_lvl & ~r_lvl_d & ~w_level[OTH];

`ifdef AUTO_REPEAT_EN
        localparam logic [1:0] ST_IDLE   = 2'd0;
        localparam logic [1:0] ST_DELAY  = 2'd1;
        localparam logic [1:0] ST_REPEAT = 2'd2;

        localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
        localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_rc;
        logic             w_rep_fire;
        logic             w_abort;

        assign w_abort = ~r_lvl | w_level[OTH];

        always_comb begin
            w_rep_fire = 1'b0;
            if (!w_abort) begin
                case (r_state)
                    ST_DELAY:  w_rep_fire = (r_rc == RD_LAST);
                    ST_REPEAT: w_rep_fire = (r_rc == RR_LAST);
                    default:   w_rep_fire = 1'b0;
                endcase
            end
        end

        // A released button or a conflicting press drops straight back to IDLE.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_rc    <= '0;
            end else if (w_abort) begin
                r_state <= ST_IDLE;
                r_rc    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_press) begin
                            r_state <= ST_DELAY;
                            r_rc    <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (r_rc == RD_LAST) begin
                            r_state <= ST_REPEAT;
                            r_rc    <= '0;
                        end else begin
                            r_rc <= r_rc + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (r_rc == RR_LAST) begin
                            r_rc <= '0;
                        end else begin
                            r_rc <= r_rc + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_rc    <= '0;
                    end
                endcase
            end
        end

        assign w_fire = w_press | w_rep_fire;
`else
        assign w_fire = w_press;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_fire;
            end
        end

        assign w_level[b] = r_lvl;
        assign w_pulse[b] = r_pulse;
    end

    assign up         = w_pulse[0];
    assign down       = w_pulse[1];
    assign up_level   = w_level[0];
    assign down_level = w_level[1];

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: expected pulses are queued as stimulus is applied and
// matched against every pulse the DUT emits. Also covers AUTO_REPEAT_EN when defined.
module tb_button_pulse_gen;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    typedef struct {
        int   e;
        logic u;
        logic d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic btn_up_raw;
    logic btn_down_raw;
    logic up;
    logic down;
    logic up_level;
    logic down_level;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   rep_next = 1000;

    button_pulse_gen #(
        .DB_CYCLES   (DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .up          (up),
        .down        (down),
        .up_level    (up_level),
        .down_level  (down_level)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int e, input logic u, input logic d);
        exp_t x;
        x.e = e;
        x.u = u;
        x.d = d;
        return x;
    endfunction

    task automatic test_reset();
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        tick();
        tick();
        checks++;
        if ({up, down, up_level, down_level} !== 4'b0000)
            $display("FAIL reset_outputs: got %b%b%b%b, expected 0000", up, down, up_level, down_level);
        if ({up, down, up_level, down_level} !== 4'b0000) errors++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_press();
        exp_t ex;
        int   e;
        exp_q.delete();
        btn_up_raw = 1'b1;
        e = DB + 3;
        exp_q.push_back(mk(e, 1'b1, 1'b0));
`ifdef AUTO_REPEAT_EN
        e += RD;
        while (e <= 40) begin
            exp_q.push_back(mk(e, 1'b1, 1'b0));
            e += RR;
        end
        rep_next = e - 40;
`endif
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (up || down) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL press_pulse: unexpected up=%b down=%b at edge %0d, expected none", up, down, t);
                end else begin
                    ex = exp_q.pop_front();
                    if (t !== ex.e || up !== ex.u || down !== ex.d) begin
                        errors++;
                        $display("FAIL press_pulse: got up=%b down=%b at edge %0d, expected up=%b down=%b at edge %0d",
                                 up, down, t, ex.u, ex.d, ex.e);
                    end
                end
            end
            if (t == DB + 1) begin
                checks++;
                if (up_level !== 1'b0) begin
                    errors++;
                    $display("FAIL press_level_early: up_level=%b at edge %0d, expected 0", up_level, t);
                end
            end
            if (t == DB + 2) begin
                checks++;
                if (up_level !== 1'b1 || down_level !== 1'b0) begin
                    errors++;
                    $display("FAIL press_level: up_level=%b down_level=%b at edge %0d, expected 1 0", up_level, down_level, t);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL press_missing: %0d pulses not seen, expected 0 outstanding", exp_q.size());
        end
    endtask

    task automatic test_release();
        exp_t ex;
        exp_q.delete();
        btn_up_raw = 1'b0;
`ifdef AUTO_REPEAT_EN
        while (rep_next <= DB + 2) begin
            exp_q.push_back(mk(rep_next, 1'b1, 1'b0));
            rep_next += RR;
        end
`endif
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (up || down) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL release_pulse: unexpected up=%b down=%b at edge %0d, expected none", up, down, t);
                end else begin
                    ex = exp_q.pop_front();
                    if (t !== ex.e || up !== ex.u || down !== ex.d) begin
                        errors++;
                        $display("FAIL release_pulse: got up=%b down=%b at edge %0d, expected up=%b down=%b at edge %0d",
                                 up, down, t, ex.u, ex.d, ex.e);
                    end
                end
            end
            if (t == DB + 1) begin
                checks++;
                if (up_level !== 1'b1) begin
                    errors++;
                    $display("FAIL release_level_early: up_level=%b at edge %0d, expected 1", up_level, t);
                end
            end
            if (t == DB + 2) begin
                checks++;
                if (up_level !== 1'b0) begin
                    errors++;
                    $display("FAIL release_level: up_level=%b at edge %0d, expected 0", up_level, t);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL release_missing: %0d pulses not seen, expected 0 outstanding", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        btn_up_raw = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t < 12 && (t % 2) == 0) btn_up_raw = ~btn_up_raw;
            checks++;
            if (up_level !== 1'b0 || up !== 1'b0 || down !== 1'b0) begin
                errors++;
                $display("FAIL bounce: up_level=%b up=%b down=%b at edge %0d, expected 0 0 0", up_level, up, down, t);
            end
        end
        btn_up_raw = 1'b0;
    endtask

    task automatic test_both();
        exp_q.delete();
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t == 20) begin
                btn_up_raw   = 1'b0;
                btn_down_raw = 1'b0;
            end
            if (up || down) begin
                checks++;
                errors++;
                $display("FAIL both_pulse: unexpected up=%b down=%b at edge %0d, expected none", up, down, t);
            end
            if (t == DB + 2) begin
                checks++;
                if (up_level !== 1'b1 || down_level !== 1'b1) begin
                    errors++;
                    $display("FAIL both_level: up_level=%b down_level=%b at edge %0d, expected 1 1", up_level, down_level, t);
                end
            end
            if (t == 30) begin
                checks++;
                if (up_level !== 1'b0 || down_level !== 1'b0) begin
                    errors++;
                    $display("FAIL both_release: up_level=%b down_level=%b at edge %0d, expected 0 0", up_level, down_level, t);
                end
            end
        end
    endtask

    task automatic test_down_then_up();
        exp_t ex;
        exp_q.delete();
        btn_down_raw = 1'b1;
        exp_q.push_back(mk(DB + 3, 1'b0, 1'b1));
        for (int t = 1; t <= 36; t++) begin
            tick();
            if (t == 10) btn_up_raw = 1'b1;
            if (t == 20) btn_down_raw = 1'b0;
            if (t == 26) btn_up_raw = 1'b0;
            if (up || down) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL blocked_pulse: unexpected up=%b down=%b at edge %0d, expected none", up, down, t);
                end else begin
                    ex = exp_q.pop_front();
                    if (t !== ex.e || up !== ex.u || down !== ex.d) begin
                        errors++;
                        $display("FAIL blocked_pulse: got up=%b down=%b at edge %0d, expected up=%b down=%b at edge %0d",
                                 up, down, t, ex.u, ex.d, ex.e);
                    end
                end
            end
            if (t == 16) begin
                checks++;
                if (up_level !== 1'b1 || down_level !== 1'b1) begin
                    errors++;
                    $display("FAIL blocked_level: up_level=%b down_level=%b at edge %0d, expected 1 1", up_level, down_level, t);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL blocked_missing: %0d pulses not seen, expected 0 outstanding", exp_q.size());
        end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        exp_t ex;
        int   e;
        int   fall;
        exp_q.delete();
        btn_up_raw = 1'b1;
        fall = 28 + DB + 2;
        e = DB + 3;
        exp_q.push_back(mk(e, 1'b1, 1'b0));
        e += RD;
        while (e <= fall) begin
            exp_q.push_back(mk(e, 1'b1, 1'b0));
            e += RR;
        end
        for (int t = 1; t <= 44; t++) begin
            tick();
            if (t == 28) btn_up_raw = 1'b0;
            if (up || down) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL repeat_pulse: unexpected up=%b down=%b at edge %0d, expected none", up, down, t);
                end else begin
                    ex = exp_q.pop_front();
                    if (t !== ex.e || up !== ex.u || down !== ex.d) begin
                        errors++;
                        $display("FAIL repeat_pulse: got up=%b down=%b at edge %0d, expected up=%b down=%b at edge %0d",
                                 up, down, t, ex.u, ex.d, ex.e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL repeat_missing: %0d pulses not seen, expected 0 outstanding", exp_q.size());
        end
    endtask
`endif

    task automatic test_reset_mid_hold();
        exp_t ex;
        exp_q.delete();
        btn_up_raw = 1'b1;
        exp_q.push_back(mk(DB + 3, 1'b1, 1'b0));
        exp_q.push_back(mk(12 + DB + 3, 1'b1, 1'b0));
        for (int t = 1; t <= 32; t++) begin
            tick();
            if (t == 10) reset = 1'b1;
            if (t == 12) reset = 1'b0;
            if (t == 22) btn_up_raw = 1'b0;
            if (up || down) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rst_hold_pulse: unexpected up=%b down=%b at edge %0d, expected none", up, down, t);
                end else begin
                    ex = exp_q.pop_front();
                    if (t !== ex.e || up !== ex.u || down !== ex.d) begin
                        errors++;
                        $display("FAIL rst_hold_pulse: got up=%b down=%b at edge %0d, expected up=%b down=%b at edge %0d",
                                 up, down, t, ex.u, ex.d, ex.e);
                    end
                end
            end
            if (t == 11 || t == 12) begin
                checks++;
                if ({up, down, up_level, down_level} !== 4'b0000) begin
                    errors++;
                    $display("FAIL rst_hold_outputs: got %b%b%b%b at edge %0d, expected 0000", up, down, up_level, down_level, t);
                end
            end
            if (t == 12 + DB + 1 || t == 12 + DB + 2) begin
                checks++;
                if (up_level !== (t == 12 + DB + 2)) begin
                    errors++;
                    $display("FAIL rst_hold_level: up_level=%b at edge %0d, expected %b", up_level, t, (t == 12 + DB + 2));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_hold_missing: %0d pulses not seen, expected 0 outstanding", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_both();
        test_down_then_up();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
